// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/LSU memory arbiter: RISC-V load/store
// funct3 encodings and the arbiter FSM state type.
package mem_arbiter_pkg;

    localparam logic [2:0] LS_LB  = 3'b000;
    localparam logic [2:0] LS_LH  = 3'b001;
    localparam logic [2:0] LS_LW  = 3'b010;
    localparam logic [2:0] LS_LBU = 3'b100;
    localparam logic [2:0] LS_LHU = 3'b101;

    localparam logic [2:0] LS_SB  = 3'b000;
    localparam logic [2:0] LS_SH  = 3'b001;
    localparam logic [2:0] LS_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RMW_RD  = 2'd2,
        RMW_WR  = 2'd3
    } state_e;

endpackage

// File: rtl/mem_arbiter_ls_align.sv
// Combinational LSU lane logic: load byte/halfword select with extension,
// store lane merge into an existing word, and misalign/illegal-type check.
module ls_align
    import mem_arbiter_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  typ,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] ldata,
    output logic [31:0] mdata,
    output logic        err
);

    logic [31:0] shifted;
    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    always_comb begin
        // Little-endian: lane n occupies bits [8n+7:8n].
        shifted = rword >> {lane, 3'b000};
        sel_b   = shifted[7:0];
        sel_h   = shifted[15:0];

        ldata = '0;
        case (typ)
            LS_LB:   ldata = {{24{sel_b[7]}}, sel_b};
            LS_LBU:  ldata = {24'h000000, sel_b};
            LS_LH:   ldata = {{16{sel_h[15]}}, sel_h};
            LS_LHU:  ldata = {16'h0000, sel_h};
            LS_LW:   ldata = rword;
            default: ldata = '0;
        endcase

        mdata = rword;
        case (typ)
            LS_SB:   mdata[{lane, 3'b000} +: 8]        = wdata[7:0];
            LS_SH:   mdata[{lane[1], 4'b0000} +: 16]   = wdata[15:0];
            default: mdata = wdata;
        endcase

        err = 1'b0;
        if (we) begin
            case (typ)
                LS_SB:   err = 1'b0;
                LS_SH:   err = lane[0];
                LS_SW:   err = |lane;
                default: err = 1'b1;
            endcase
        end else begin
            case (typ)
                LS_LB, LS_LBU: err = 1'b0;
                LS_LH, LS_LHU: err = lane[0];
                LS_LW:         err = |lane;
                default:       err = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between an
// instruction fetch port and a load/store unit with sub-word read-modify-write.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [31:0]   ls_addr,
    input  logic [31:0]   ls_wdata,
    input  logic [2:0]    ls_type,
    output logic          ls_gnt,
    output logic          ls_done,
    output logic [31:0]   ls_rdata,
    output logic          ls_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic [1:0]    dbg_state
);

    state_e        state;
    logic          last_fetch;
    logic          rd_ls_q;
    logic [2:0]    typ_q;
    logic [1:0]    lane_q;
    logic [31:0]   wdata_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   if_hold;
    logic [31:0]   ls_hold;
    logic          accepting;
    logic          chk_err;
    logic [31:0]   dat_ldata;
    logic [31:0]   dat_mdata;
    logic [31:0]   unused_ldata;
    logic [31:0]   unused_mdata;
    logic          unused_err;
    logic          unused_bits;

    // Live request fields: only the error check is consumed.
    ls_align u_chk (
        .we    (ls_we),
        .typ   (ls_type),
        .lane  (ls_addr[1:0]),
        .wdata (ls_wdata),
        .rword (mem_rdata),
        .ldata (unused_ldata),
        .mdata (unused_mdata),
        .err   (chk_err)
    );

    // Fields latched at grant: load extraction and store merge.
    ls_align u_dat (
        .we    (1'b1),
        .typ   (typ_q),
        .lane  (lane_q),
        .wdata (wdata_q),
        .rword (mem_rdata),
        .ldata (dat_ldata),
        .mdata (dat_mdata),
        .err   (unused_err)
    );

    assign unused_bits = ^{if_addr[31:AW+2], if_addr[1:0], ls_addr[31:AW+2]};

    // RD_WAIT only returns data and leaves the memory port free, so it
    // accepts a new grant like IDLE to allow back-to-back reads.
    assign accepting = rst_n && (state == IDLE || state == RD_WAIT);

    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        if (accepting) begin
            if (if_req && ls_req) begin
                if (last_fetch) ls_gnt = 1'b1;
                else            if_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end else if (ls_req) begin
                ls_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_en   = 1'b1;
            mem_addr = if_addr[AW+1:2];
        end else if (ls_gnt && !chk_err) begin
            mem_en   = 1'b1;
            mem_addr = ls_addr[AW+1:2];
            if (ls_we && ls_type == LS_SW) begin
                mem_we    = 1'b1;
                mem_wdata = ls_wdata;
            end
        end else if (state == RMW_RD) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = dat_mdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_fetch <= 1'b1;
            rd_ls_q    <= 1'b0;
            typ_q      <= '0;
            lane_q     <= '0;
            wdata_q    <= '0;
            addr_q     <= '0;
            if_hold    <= '0;
            ls_hold    <= '0;
            if_rvalid  <= 1'b0;
            ls_done    <= 1'b0;
            ls_err     <= 1'b0;
        end else begin
            if_rvalid <= 1'b0;
            ls_done   <= 1'b0;
            ls_err    <= 1'b0;
            if (state == RD_WAIT) begin
                if (rd_ls_q) ls_hold <= dat_ldata;
                else         if_hold <= mem_rdata;
            end
            case (state)
                IDLE, RD_WAIT: begin
                    state <= IDLE;
                    if (if_gnt) begin
                        last_fetch <= 1'b1;
                        rd_ls_q    <= 1'b0;
                        if_rvalid  <= 1'b1;
                        state      <= RD_WAIT;
                    end else if (ls_gnt) begin
                        last_fetch <= 1'b0;
                        typ_q      <= ls_type;
                        lane_q     <= ls_addr[1:0];
                        wdata_q    <= ls_wdata;
                        addr_q     <= ls_addr[AW+1:2];
                        if (chk_err) begin
                            ls_done <= 1'b1;
                            ls_err  <= 1'b1;
                            ls_hold <= '0;
                        end else if (!ls_we) begin
                            rd_ls_q <= 1'b1;
                            ls_done <= 1'b1;
                            state   <= RD_WAIT;
                        end else if (ls_type == LS_SW) begin
                            ls_done <= 1'b1;
                        end else begin
                            state <= RMW_RD;
                        end
                    end
                end
                RMW_RD: begin
                    state   <= RMW_WR;
                    ls_done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign if_rdata  = (state == RD_WAIT && !rd_ls_q) ? mem_rdata : if_hold;
    assign ls_rdata  = (state == RD_WAIT && rd_ls_q)  ? dat_ldata : ls_hold;
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port memory and
// expected-data queues for load and fetch returns.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req, ls_we;
    logic [31:0] ls_addr, ls_wdata;
    logic [2:0]  ls_type;
    logic        ls_gnt, ls_done, ls_err;
    logic [31:0] ls_rdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [1:0]  dbg_state;

    logic [31:0] mem [0:255];
    logic        bd_we;
    logic [7:0]  bd_addr;
    logic [31:0] bd_data;

    logic [31:0] exp_q[$];
    logic [31:0] if_q[$];
    int          errors = 0;
    int          checks = 0;

    mem_arbiter #(.AW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_type(ls_type), .ls_gnt(ls_gnt), .ls_done(ls_done),
        .ls_rdata(ls_rdata), .ls_err(ls_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bd_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic ls_drive(input logic we, input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        ls_req = 1'b1; ls_we = we; ls_type = t; ls_addr = a; ls_wdata = d;
        #1;
        check1("ls_gnt", ls_gnt, 1'b1);
    endtask

    task automatic load(input logic [2:0] t, input logic [31:0] a, input logic [31:0] expv);
        ls_drive(1'b0, t, a, 32'h0);
        check1("ld_mem_en", mem_en, 1'b1);
        check1("ld_mem_we", mem_we, 1'b0);
        check32("ld_mem_addr", {24'h0, mem_addr}, {24'h0, a[9:2]});
        exp_q.push_back(expv);
        @(negedge clk);
        ls_req = 1'b0;
        #1;
        check1("ld_done", ls_done, 1'b1);
        check1("ld_err", ls_err, 1'b0);
        if (ls_done && exp_q.size() > 0) check32("ld_rdata", ls_rdata, exp_q.pop_front());
    endtask

    task automatic store_word(input logic [31:0] a, input logic [31:0] d);
        ls_drive(1'b1, LS_SW, a, d);
        check1("sw_mem_en", mem_en, 1'b1);
        check1("sw_mem_we", mem_we, 1'b1);
        check32("sw_mem_addr", {24'h0, mem_addr}, {24'h0, a[9:2]});
        check32("sw_mem_wdata", mem_wdata, d);
        @(negedge clk);
        ls_req = 1'b0;
        #1;
        check1("sw_done", ls_done, 1'b1);
        check1("sw_err", ls_err, 1'b0);
        check1("sw_no_mem", mem_en, 1'b0);
    endtask

    task automatic store_sub(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] expw);
        ls_drive(1'b1, t, a, d);
        check1("rmw_rd_en", mem_en, 1'b1);
        check1("rmw_rd_we", mem_we, 1'b0);
        check32("rmw_rd_addr", {24'h0, mem_addr}, {24'h0, a[9:2]});
        @(negedge clk);
        ls_req = 1'b0; if_req = 1'b1; if_addr = 32'h0;
        #1;
        check1("rmw_if_gnt_blocked", if_gnt, 1'b0);
        check1("rmw_wr_en", mem_en, 1'b1);
        check1("rmw_wr_we", mem_we, 1'b1);
        check32("rmw_wr_addr", {24'h0, mem_addr}, {24'h0, a[9:2]});
        check32("rmw_wr_data", mem_wdata, expw);
        check1("rmw_done_early", ls_done, 1'b0);
        @(negedge clk);
        if_req = 1'b0;
        #1;
        check1("rmw_done", ls_done, 1'b1);
        check1("rmw_err", ls_err, 1'b0);
        check32("rmw_mem_word", mem[a[9:2]], expw);
    endtask

    task automatic ls_error(input logic we, input logic [2:0] t, input logic [31:0] a);
        ls_drive(we, t, a, 32'hFFFF_FFFF);
        check1("err_no_mem_en", mem_en, 1'b0);
        check1("err_no_mem_we", mem_we, 1'b0);
        @(negedge clk);
        ls_req = 1'b0;
        #1;
        check1("err_done", ls_done, 1'b1);
        check1("err_flag", ls_err, 1'b1);
        check32("err_rdata", ls_rdata, 32'h0);
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] expv);
        @(negedge clk);
        if_req = 1'b1; if_addr = a;
        #1;
        check1("if_gnt", if_gnt, 1'b1);
        check1("if_mem_en", mem_en, 1'b1);
        check1("if_mem_we", mem_we, 1'b0);
        check32("if_mem_addr", {24'h0, mem_addr}, {24'h0, a[9:2]});
        if_q.push_back(expv);
        @(negedge clk);
        if_req = 1'b0;
        #1;
        check1("if_rvalid", if_rvalid, 1'b1);
        if (if_rvalid && if_q.size() > 0) check32("if_rdata", if_rdata, if_q.pop_front());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        if_req = 1'b1; if_addr = 32'h0;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0; ls_wdata = '0; ls_type = LS_LW;

        bd_write(8'h10, 32'h8899AABB);
        bd_write(8'h11, 32'hCAFEF00D);
        bd_write(8'h12, 32'h55667788);

        // Reset state with both requests pending.
        #1;
        check1("rst_if_gnt", if_gnt, 1'b0);
        check1("rst_ls_gnt", ls_gnt, 1'b0);
        check1("rst_mem_en", mem_en, 1'b0);
        check1("rst_mem_we", mem_we, 1'b0);
        check1("rst_if_rvalid", if_rvalid, 1'b0);
        check1("rst_ls_done", ls_done, 1'b0);
        check1("rst_ls_err", ls_err, 1'b0);
        check32("rst_if_rdata", if_rdata, 32'h0);
        check32("rst_ls_rdata", ls_rdata, 32'h0);
        check32("rst_state", {30'h0, dbg_state}, 32'h0);

        @(negedge clk);
        if_req = 1'b0; ls_req = 1'b0;
        rst_n = 1'b1;

        // Loads with sign/zero extension from word 0x10 = 0x8899AABB.
        load(LS_LB,  32'h41, 32'hFFFFFFAA);
        load(LS_LBU, 32'h41, 32'h000000AA);
        @(negedge clk);
        #1;
        check1("ld_done_pulse", ls_done, 1'b0);
        check32("ld_rdata_hold", ls_rdata, 32'h000000AA);
        load(LS_LB,  32'h40, 32'hFFFFFFBB);
        load(LS_LBU, 32'h42, 32'h00000099);
        load(LS_LB,  32'h43, 32'hFFFFFF88);
        load(LS_LH,  32'h42, 32'hFFFF8899);
        load(LS_LH,  32'h40, 32'hFFFFAABB);
        load(LS_LHU, 32'h40, 32'h0000AABB);
        load(LS_LW,  32'h40, 32'h8899AABB);

        // Sub-word stores through read-modify-write.
        store_sub(LS_SB, 32'h42, 32'h00000011, 32'h8811AABB);
        load(LS_LW, 32'h40, 32'h8811AABB);
        store_sub(LS_SH, 32'h46, 32'h00001234, 32'h1234F00D);
        load(LS_LW, 32'h44, 32'h1234F00D);
        store_word(32'h44, 32'hDEADBEEF);
        load(LS_LW, 32'h44, 32'hDEADBEEF);

        // Misaligned and illegal accesses.
        ls_error(1'b0, LS_LW,  32'h42);
        ls_error(1'b0, LS_LH,  32'h41);
        ls_error(1'b0, LS_LHU, 32'h43);
        ls_error(1'b1, LS_SH,  32'h43);
        ls_error(1'b1, LS_SW,  32'h41);
        ls_error(1'b0, 3'b011, 32'h40);
        ls_error(1'b1, 3'b100, 32'h40);
        check32("err_mem_untouched", mem[8'h10], 32'h8811AABB);

        // Fetch ignores the byte offset.
        fetch(32'h46, 32'hDEADBEEF);
        fetch(32'h40, 32'h8811AABB);
        @(negedge clk);
        #1;
        check1("if_rvalid_pulse", if_rvalid, 1'b0);
        check32("if_rdata_hold", if_rdata, 32'h8811AABB);

        // Round robin from reset with both requesters continuously active.
        @(negedge clk);
        rst_n = 1'b0;
        if_req = 1'b1; if_addr = 32'h44;
        ls_req = 1'b1; ls_we = 1'b0; ls_type = LS_LW; ls_addr = 32'h40;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            check1("rr_ls_gnt", ls_gnt, (k % 2 == 0));
            check1("rr_if_gnt", if_gnt, (k % 2 == 1));
            check1("rr_ls_done", ls_done, (k > 0) && ((k - 1) % 2 == 0));
            check1("rr_if_rvalid", if_rvalid, (k > 0) && ((k - 1) % 2 == 1));
            if (ls_done && exp_q.size() > 0) check32("rr_ls_rdata", ls_rdata, exp_q.pop_front());
            if (if_rvalid && if_q.size() > 0) check32("rr_if_rdata", if_rdata, if_q.pop_front());
            if (k % 2 == 0) exp_q.push_back(32'h8811AABB);
            else            if_q.push_back(32'hDEADBEEF);
        end
        @(negedge clk);
        if_req = 1'b0; ls_req = 1'b0;
        #1;
        check1("rr_last_rvalid", if_rvalid, 1'b1);
        if (if_rvalid && if_q.size() > 0) check32("rr_last_if_rdata", if_rdata, if_q.pop_front());

        // Reset while the SH read-modify-write is in flight.
        store_word(32'h0, 32'h0);
        ls_drive(1'b1, LS_SH, 32'h48, 32'h0000BEEF);
        check1("abort_rd_en", mem_en, 1'b1);
        @(negedge clk);
        ls_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check1("abort_mem_en", mem_en, 1'b0);
        check1("abort_mem_we", mem_we, 1'b0);
        check32("abort_state", {30'h0, dbg_state}, 32'h0);
        check1("abort_done_a", ls_done, 1'b0);
        @(negedge clk);
        #1;
        check1("abort_done_b", ls_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check32("abort_state_idle", {30'h0, dbg_state}, 32'h0);
        check1("abort_done_c", ls_done, 1'b0);
        @(negedge clk);
        #1;
        check1("abort_done_d", ls_done, 1'b0);
        check32("abort_mem_word", mem[8'h12], 32'h55667788);
        load(LS_LW, 32'h48, 32'h55667788);

        check32("ls_queue_empty", exp_q.size(), 32'h0);
        check32("if_queue_empty", if_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 8: word-address width of the shared data memory (256 words).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 if_req  in  1  fetch-port read request; if_addr  in  32  byte address.
REQ-005 if_gnt  out  1  fetch request accepted this cycle; if_rvalid  out  1  read data valid; if_rdata  out  32  word read.
REQ-006 ls_req  in  1  LSU request; ls_we  in  1  1=store; ls_addr  in  32  byte address; ls_wdata  in  32  store data, low-aligned; ls_type  in  3  RISC-V funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
REQ-007 ls_gnt  out  1  LSU request accepted; ls_done  out  1  completion pulse (load data or store retired); ls_rdata  out  32  extended load result; ls_err  out  1  misaligned or illegal type, valid with ls_done.
REQ-008 mem_en  out  1; mem_we  out  1; mem_addr  out  AW  word index; mem_wdata  out  32; mem_rdata  in  32, valid one cycle after mem_en with mem_we=0.

Function
REQ-009 FSM states IDLE, RD_WAIT, RMW_RD, RMW_WR; grants are issued only in IDLE; if_gnt/ls_gnt are combinational from req and state.
REQ-010 Requesters SHALL hold req and all fields stable until gnt; arbiter samples fields only in the grant cycle.
REQ-011 Both req in IDLE: round-robin, grant the port not granted last; single req granted immediately; pointer updates on every grant.
REQ-012 Word index = addr[AW+1:2]; byte lane = addr[1:0]; little-endian lanes.
REQ-013 Fetch/load grant at T: mem read at T, state RD_WAIT, at T+1 rvalid/done asserted for one cycle with data, return to IDLE (new grant possible at T+1).
REQ-014 LB/LH sign-extend, LBU/LHU zero-extend the selected byte/halfword into bits [31:0]; LW passes the word.
REQ-015 SW grant at T: mem write at T with full word, ls_done at T+1.
REQ-016 SB/SH grant at T: read at T (RMW_RD), at T+1 write merged word (unselected lanes from mem_rdata) (RMW_WR), ls_done at T+2; no grant at T+1.
REQ-017 Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) or illegal ls_type: granted, no mem_en, ls_done+ls_err at T+1, ls_rdata=0.
REQ-018 if_addr[1:0]!=0 is ignored (word fetched); fetch has no error path.
REQ-019 mem_en/mem_we SHALL never assert outside the cycles in REQ-013..016; at most one mem access per cycle.
REQ-020 ls_rdata and if_rdata hold the last returned value when not valid.

Reset
REQ-021 rst_n low: state IDLE, all outputs 0, round-robin pointer = fetch-last (LSU wins first conflict).
REQ-022 Reset during RD_WAIT/RMW_RD/RMW_WR aborts the operation: no write issued, no done/rvalid pulse.

Structure
REQ-023 Shared package holds ls_type encodings (LB..LHU, SB..SW) and FSM state enum, reused by the decoder and LSU.
REQ-024 One sub-module, ls_align: combinational lane select/extend for loads and lane merge/misalign check for stores.
REQ-025 Target 150-300 lines RTL including ls_align.

Verification
REQ-026 Memory word 0x10 = 0x8899AABB; LB addr 0x41 -> ls_done at T+1, ls_rdata 0xFFFFFFAA; LBU -> 0x000000AA.
REQ-027 SB addr 0x42 data 0x11 onto 0x8899AABB -> read T, write T+1 of 0x8811AABB, ls_done T+2, if_gnt low at T+1.
REQ-028 if_req and ls_req held high 4 cycles from reset, both loads -> grants alternate LSU, fetch, LSU, fetch.
REQ-029 LW addr 0x42 -> no mem_en, ls_done+ls_err at T+1, ls_rdata 0.
REQ-030 rst_n low during RMW_RD of SH -> memory word unchanged, no ls_done, IDLE after release.
REQ-031 SW addr 0x44 data 0xDEADBEEF then LW same addr -> ls_rdata 0xDEADBEEF.
